// File: rtl/gig_eth_tx_arbiter.sv
// Two-source round-robin frame scheduler feeding the gigabit MAC TX client interface.
// One source is granted per frame; byte 0 is held until mac_tx_ack, then the frame streams gap-free.
module gig_eth_tx_arbiter #(
  parameter int unsigned MAX_FRAME_BYTES = 9018,
  parameter int unsigned GAP_CYCLES      = 2,
  parameter int unsigned ACK_TIMEOUT     = 64
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  src0_data,
  input  logic        src0_valid,
  input  logic        src0_last,
  output logic        src0_ready,
  input  logic [7:0]  src1_data,
  input  logic        src1_valid,
  input  logic        src1_last,
  output logic        src1_ready,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  output logic        mac_tx_underrun,
  input  logic        mac_tx_ack,
  output logic        grant,
  output logic        busy,
  output logic [15:0] abort_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitAck,
    StStream,
    StAbort,
    StDrain,
    StGap
  } state_e;

  // byte_cnt counts bytes popped after byte 0, so the pop of byte N sees byte_cnt == N-2.
  localparam logic [13:0] ByteLimit = 14'(MAX_FRAME_BYTES - 2);
  localparam logic [6:0]  AckLimit  = 7'(ACK_TIMEOUT - 1);
  localparam logic [6:0]  GapLimit  = 7'(GAP_CYCLES - 1);

  state_e      state_q;
  logic        rr_q;
  logic        last_seen_q;
  logic [13:0] byte_cnt_q;
  logic [6:0]  timer_q;

  logic       any_valid;
  logic       pick;
  logic       sel;
  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;
  logic       pop;

  always_comb begin
    any_valid = src0_valid | src1_valid;
    if (rr_q) pick = src1_valid ? 1'b1 : 1'b0;
    else      pick = src0_valid ? 1'b0 : 1'b1;
    sel       = (state_q == StIdle) ? pick : grant;
    sel_data  = sel ? src1_data  : src0_data;
    sel_valid = sel ? src1_valid : src0_valid;
    sel_last  = sel ? src1_last  : src0_last;
    pop       = 1'b0;
    case (state_q)
      StIdle:    pop = enable & any_valid;
      StWaitAck: pop = mac_tx_ack & ~last_seen_q;
      StStream:  pop = ~last_seen_q;
      StDrain:   pop = 1'b1;
      default:   pop = 1'b0;
    endcase
    if (reset) pop = 1'b0;
    src0_ready = pop & ~sel;
    src1_ready = pop & sel;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      rr_q            <= 1'b0;
      last_seen_q     <= 1'b0;
      byte_cnt_q      <= '0;
      timer_q         <= '0;
      grant           <= 1'b0;
      mac_tx_data     <= '0;
      mac_tx_dvld     <= 1'b0;
      mac_tx_underrun <= 1'b0;
      abort_cnt       <= '0;
    end else begin
      mac_tx_underrun <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable && any_valid) begin
            grant       <= pick;
            rr_q        <= ~pick;
            mac_tx_data <= sel_data;
            mac_tx_dvld <= 1'b1;
            last_seen_q <= sel_last;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            state_q     <= StWaitAck;
          end
        end
        StWaitAck, StStream: begin
          if (state_q == StWaitAck && !mac_tx_ack) begin
            if (timer_q == AckLimit) begin
              mac_tx_underrun <= 1'b1;
              state_q         <= StAbort;
            end else begin
              timer_q <= timer_q + 7'd1;
            end
          end else if (last_seen_q) begin
            // Final byte has had its one presentation cycle.
            mac_tx_dvld <= 1'b0;
            timer_q     <= '0;
            state_q     <= StGap;
          end else if (!sel_valid) begin
            mac_tx_underrun <= 1'b1;
            state_q         <= StAbort;
          end else begin
            mac_tx_data <= sel_data;
            byte_cnt_q  <= byte_cnt_q + 14'd1;
            last_seen_q <= sel_last;
            state_q     <= StStream;
            if (!sel_last && byte_cnt_q == ByteLimit) begin
              mac_tx_underrun <= 1'b1;
              state_q         <= StAbort;
            end
          end
        end
        StAbort: begin
          mac_tx_dvld <= 1'b0;
          timer_q     <= '0;
          if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
          state_q <= last_seen_q ? StGap : StDrain;
        end
        StDrain: begin
          if (sel_valid && sel_last) begin
            timer_q <= '0;
            state_q <= StGap;
          end
        end
        StGap: begin
          if (timer_q == GapLimit) state_q <= StIdle;
          else                     timer_q <= timer_q + 7'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gig_eth_tx_arbiter.sv
// Directed bench for gig_eth_tx_arbiter: framing, round-robin, aborts, oversize and reset.
module tb_gig_eth_tx_arbiter;

  localparam int MaxBytes = 9018;

  logic        tx_clk;
  logic        reset;
  logic        enable;
  logic [7:0]  src0_data;
  logic        src0_valid;
  logic        src0_last;
  logic        src0_ready;
  logic [7:0]  src1_data;
  logic        src1_valid;
  logic        src1_last;
  logic        src1_ready;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_underrun;
  logic        mac_tx_ack;
  logic        grant;
  logic        busy;
  logic [15:0] abort_cnt;

  int vectors;
  int miscompares;
  int dv_cnt;
  int bad;

  gig_eth_tx_arbiter dut (
    .tx_clk          (tx_clk),
    .reset           (reset),
    .enable          (enable),
    .src0_data       (src0_data),
    .src0_valid      (src0_valid),
    .src0_last       (src0_last),
    .src0_ready      (src0_ready),
    .src1_data       (src1_data),
    .src1_valid      (src1_valid),
    .src1_last       (src1_last),
    .src1_ready      (src1_ready),
    .mac_tx_data     (mac_tx_data),
    .mac_tx_dvld     (mac_tx_dvld),
    .mac_tx_underrun (mac_tx_underrun),
    .mac_tx_ack      (mac_tx_ack),
    .grant           (grant),
    .busy            (busy),
    .abort_cnt       (abort_cnt)
  );

  initial begin
    tx_clk = 1'b0;
    forever #5 tx_clk = ~tx_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge tx_clk);
    #1;
    if (mac_tx_dvld === 1'b1) dv_cnt++;
  endtask

  task automatic wait_dvld(input string tag);
    int n;
    n = 0;
    while (mac_tx_dvld !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mac_tx_dvld}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; dv_cnt = 0; bad = 0;
    reset = 1'b1; enable = 1'b0; mac_tx_ack = 1'b0;
    src0_data = '0; src0_valid = 1'b0; src0_last = 1'b0;
    src1_data = '0; src1_valid = 1'b0; src1_last = 1'b0;
    tick();

    // Reset state, with a requesting source to prove ready stays low.
    enable = 1'b1; src0_valid = 1'b1;
    #1;
    chk("rst dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("rst underrun", {31'd0, mac_tx_underrun}, 32'd0);
    chk("rst data", {24'd0, mac_tx_data}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst grant", {31'd0, grant}, 32'd0);
    chk("rst abort_cnt", {16'd0, abort_cnt}, 32'd0);
    chk("rst ready0", {31'd0, src0_ready}, 32'd0);
    src0_valid = 1'b0; enable = 1'b0;
    reset = 1'b0;
    tick();

    // Frame AA BB CC DD, ack raised on the 4th dvld cycle.
    dv_cnt = 0;
    src0_data = 8'hAA; src0_valid = 1'b1; enable = 1'b1;
    #1;
    chk("f1 idle ready0", {31'd0, src0_ready}, 32'd1);
    chk("f1 idle ready1", {31'd0, src1_ready}, 32'd0);
    tick();
    chk("f1 c1 dvld", {31'd0, mac_tx_dvld}, 32'd1);
    chk("f1 c1 data", {24'd0, mac_tx_data}, 32'hAA);
    chk("f1 c1 grant", {31'd0, grant}, 32'd0);
    chk("f1 c1 busy", {31'd0, busy}, 32'd1);
    src0_data = 8'hBB;
    #1;
    chk("f1 hold ready0", {31'd0, src0_ready}, 32'd0);
    tick();
    tick();
    tick();
    chk("f1 c4 data", {24'd0, mac_tx_data}, 32'hAA);
    mac_tx_ack = 1'b1;
    #1;
    chk("f1 ack ready0", {31'd0, src0_ready}, 32'd1);
    tick();
    mac_tx_ack = 1'b0;
    chk("f1 c5 data", {24'd0, mac_tx_data}, 32'hBB);
    src0_data = 8'hCC;
    tick();
    chk("f1 c6 data", {24'd0, mac_tx_data}, 32'hCC);
    src0_data = 8'hDD; src0_last = 1'b1;
    tick();
    chk("f1 c7 data", {24'd0, mac_tx_data}, 32'hDD);
    chk("f1 c7 dvld", {31'd0, mac_tx_dvld}, 32'd1);
    src0_valid = 1'b0; src0_last = 1'b0;
    #1;
    chk("f1 c7 ready0", {31'd0, src0_ready}, 32'd0);
    tick();
    chk("f1 gap1 dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("f1 gap1 busy", {31'd0, busy}, 32'd1);
    tick();
    chk("f1 gap2 dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("f1 gap2 busy", {31'd0, busy}, 32'd1);
    tick();
    chk("f1 idle busy", {31'd0, busy}, 32'd0);
    chk("f1 dvld cycles", dv_cnt, 32'd7);

    // Fresh reset, both sources offering 1-byte frames: grants 0,1,0.
    reset = 1'b1; #1; reset = 1'b0;
    src0_data = 8'h10; src0_valid = 1'b1; src0_last = 1'b1;
    src1_data = 8'h21; src1_valid = 1'b1; src1_last = 1'b1;
    mac_tx_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_dvld("rr dvld wait");
      chk("rr grant", {31'd0, grant}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr data", {24'd0, mac_tx_data}, (k % 2 == 1) ? 32'h21 : 32'h10);
      chk("rr ack ready0", {31'd0, src0_ready}, 32'd0);
      chk("rr ack ready1", {31'd0, src1_ready}, 32'd0);
      tick();
      chk("rr dvld drop", {31'd0, mac_tx_dvld}, 32'd0);
    end
    enable = 1'b0; mac_tx_ack = 1'b0;
    src0_valid = 1'b0; src0_last = 1'b0; src1_valid = 1'b0; src1_last = 1'b0;
    wait_idle("rr idle wait");

    // src1 10-byte frame starves after 5 bytes.
    enable = 1'b1; mac_tx_ack = 1'b1;
    src1_data = 8'h50; src1_valid = 1'b1;
    #1;
    chk("st idle ready1", {31'd0, src1_ready}, 32'd1);
    tick();
    chk("st grant", {31'd0, grant}, 32'd1);
    chk("st c1 data", {24'd0, mac_tx_data}, 32'h50);
    for (int i = 1; i < 5; i++) begin
      src1_data = 8'(32'h50 + i);
      tick();
      chk("st stream data", {24'd0, mac_tx_data}, 32'h50 + i);
    end
    src1_valid = 1'b0;
    tick();
    chk("st abort dvld", {31'd0, mac_tx_dvld}, 32'd1);
    chk("st abort underrun", {31'd0, mac_tx_underrun}, 32'd1);
    chk("st abort ready1", {31'd0, src1_ready}, 32'd0);
    src1_data = 8'h55; src1_valid = 1'b1;
    tick();
    chk("st drain dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("st drain underrun", {31'd0, mac_tx_underrun}, 32'd0);
    chk("st abort_cnt", {16'd0, abort_cnt}, 32'd1);
    chk("st drain ready1", {31'd0, src1_ready}, 32'd1);
    bad = 0;
    for (int i = 6; i < 10; i++) begin
      tick();
      src1_data = 8'(32'h50 + i); src1_last = (i == 9);
      if (mac_tx_dvld !== 1'b0) bad++;
    end
    chk("st drain dvld low", bad, 32'd0);
    tick();
    src1_valid = 1'b0; src1_last = 1'b0; mac_tx_ack = 1'b0;
    chk("st gap busy", {31'd0, busy}, 32'd1);
    wait_idle("st idle wait");

    // Ack withheld: abort after 64 cycles in WAIT_ACK.
    src0_data = 8'h60; src0_valid = 1'b1;
    tick();
    chk("to grant", {31'd0, grant}, 32'd0);
    src0_data = 8'h61;
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      if (mac_tx_underrun !== 1'b0 || mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'h60) bad++;
      tick();
    end
    chk("to hold", bad, 32'd0);
    chk("to c64 underrun", {31'd0, mac_tx_underrun}, 32'd0);
    chk("to c64 ready0", {31'd0, src0_ready}, 32'd0);
    tick();
    chk("to abort underrun", {31'd0, mac_tx_underrun}, 32'd1);
    chk("to abort dvld", {31'd0, mac_tx_dvld}, 32'd1);
    tick();
    chk("to drain dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("to abort_cnt", {16'd0, abort_cnt}, 32'd2);
    src0_last = 1'b1;
    tick();
    src0_valid = 1'b0; src0_last = 1'b0;
    wait_idle("to idle wait");

    // Oversize frame: underrun accompanies byte MaxBytes.
    mac_tx_ack = 1'b1;
    src0_data = 8'h00; src0_valid = 1'b1;
    tick();
    bad = 0;
    for (int n = 2; n < MaxBytes; n++) begin
      src0_data = 8'(n - 1);
      tick();
      if (mac_tx_underrun !== 1'b0 || mac_tx_dvld !== 1'b1 || mac_tx_data !== 8'(n - 1)) bad++;
    end
    chk("ov stream", bad, 32'd0);
    src0_data = 8'(MaxBytes - 1);
    tick();
    chk("ov underrun", {31'd0, mac_tx_underrun}, 32'd1);
    chk("ov dvld", {31'd0, mac_tx_dvld}, 32'd1);
    chk("ov data", {24'd0, mac_tx_data}, 32'h39);
    tick();
    chk("ov abort_cnt", {16'd0, abort_cnt}, 32'd3);
    chk("ov drain busy", {31'd0, busy}, 32'd1);

    // Reset mid-drain and mid-stream.
    reset = 1'b1;
    #1;
    chk("rd busy", {31'd0, busy}, 32'd0);
    chk("rd abort_cnt", {16'd0, abort_cnt}, 32'd0);
    chk("rd ready0", {31'd0, src0_ready}, 32'd0);
    src0_valid = 1'b0;
    reset = 1'b0;
    src1_data = 8'h70; src1_valid = 1'b1;
    tick();
    chk("rs grant", {31'd0, grant}, 32'd1);
    src1_data = 8'h71;
    tick();
    chk("rs data", {24'd0, mac_tx_data}, 32'h71);
    chk("rs dvld", {31'd0, mac_tx_dvld}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rs rst dvld", {31'd0, mac_tx_dvld}, 32'd0);
    chk("rs rst data", {24'd0, mac_tx_data}, 32'd0);
    chk("rs rst grant", {31'd0, grant}, 32'd0);
    chk("rs rst busy", {31'd0, busy}, 32'd0);
    chk("rs rst ready1", {31'd0, src1_ready}, 32'd0);
    tick();
    chk("rs rst edge dvld", {31'd0, mac_tx_dvld}, 32'd0);
    src0_data = 8'h80; src0_valid = 1'b1;
    reset = 1'b0;
    tick();
    chk("rs regrant", {31'd0, grant}, 32'd0);
    chk("rs regrant data", {24'd0, mac_tx_data}, 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
